// File: rtl/pipelined_carry_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_carry_adder
// Brief    : WIDTH-bit add/subtract split into STAGES carry-ripple chunks,
//            valid/ready on both sides. PIPELINED_CARRY_ADDER_OVF_EN adds ovf.
// Revision : 1.0
// ============================================================================
module pipelined_carry_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef PIPELINED_CARRY_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int CHUNK = WIDTH / STAGES;

  if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_param_err
    $error("pipelined_carry_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
  end

  logic             r_vld [STAGES];
  logic             r_cy  [STAGES];
  logic [WIDTH-1:0] r_a   [STAGES];
  logic [WIDTH-1:0] r_b   [STAGES];
  logic [WIDTH-1:0] r_sum [STAGES];

  logic             w_vld_in [STAGES];
  logic             w_c_in   [STAGES];
  logic [WIDTH-1:0] w_a_in   [STAGES];
  logic [WIDTH-1:0] w_b_in   [STAGES];
  logic [WIDTH-1:0] w_sum_in [STAGES];
  logic [CHUNK:0]   w_part   [STAGES];
  logic [WIDTH-1:0] w_sum_out[STAGES];
  logic             w_adv;

  assign w_adv    = !r_vld[STAGES-1] | out_ready;
  assign in_ready = w_adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      // Subtract is a + ~b + ~cin, so the inversion is folded in here once.
      assign w_vld_in[k] = in_valid;
      assign w_a_in[k]   = a;
      assign w_b_in[k]   = b ^ {WIDTH{sub}};
      assign w_c_in[k]   = cin ^ sub;
      assign w_sum_in[k] = '0;
    end else begin : g_next
      assign w_vld_in[k] = r_vld[k-1];
      assign w_a_in[k]   = r_a[k-1];
      assign w_b_in[k]   = r_b[k-1];
      assign w_c_in[k]   = r_cy[k-1];
      assign w_sum_in[k] = r_sum[k-1];
    end

    assign w_part[k] = {1'b0, w_a_in[k][k*CHUNK +: CHUNK]}
                     + {1'b0, w_b_in[k][k*CHUNK +: CHUNK]}
                     + {{CHUNK{1'b0}}, w_c_in[k]};

    // Bits at and above chunk k of the incoming partial sum are still zero.
    assign w_sum_out[k] = w_sum_in[k] | (WIDTH'(w_part[k][CHUNK-1:0]) << (k*CHUNK));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_vld[k] <= 1'b0;
        r_cy[k]  <= 1'b0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_sum[k] <= '0;
      end
    end else if (w_adv) begin
      for (int k = 0; k < STAGES; k++) begin
        r_vld[k] <= w_vld_in[k];
        r_cy[k]  <= w_part[k][CHUNK];
        r_a[k]   <= w_a_in[k];
        r_b[k]   <= w_b_in[k];
        r_sum[k] <= w_sum_out[k];
      end
    end
  end

  assign out_valid = r_vld[STAGES-1];
  assign sum       = r_sum[STAGES-1];
  assign cout      = r_cy[STAGES-1];

`ifdef PIPELINED_CARRY_ADDER_OVF_EN
  logic w_msb_cin;
  logic r_ovf;

  // Carry into the MSB is recovered from the MSB operand and result bits.
  assign w_msb_cin = w_a_in[STAGES-1][WIDTH-1] ^ w_b_in[STAGES-1][WIDTH-1]
                   ^ w_sum_out[STAGES-1][WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      r_ovf <= w_msb_cin ^ w_part[STAGES-1][CHUNK];
    end
  end

  assign ovf = r_ovf;
`endif

endmodule
`default_nettype wire

// File: doc/pipelined_carry_adder.md
Name: pipelined_carry_adder

Overview:
- Parametrised successor of the 4-bit combinational ripple-carry adder.
- Splits a WIDTH-bit add/subtract into STAGES equal carry-ripple chunks, one chunk per pipeline stage.
- Uses a valid/ready handshake on both sides and accepts one operation per cycle when not back-pressured.
- Serves as the datapath adder for the team's wider arithmetic units.

Parameters:
WIDTH, 16, operand and sum width in bits; must be a multiple of STAGES.
STAGES, 4, number of pipeline stages; 1 <= STAGES <= WIDTH. CHUNK = WIDTH/STAGES bits per stage.

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operation present on a, b, cin, sub
in_ready  output  1  block accepts operation this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in (borrow-in when sub=1)
sub  input  1  0: add, 1: subtract
out_valid  output  1  result present on sum, cout
out_ready  input  1  downstream accepts result this cycle
sum  output  WIDTH  result, modulo 2^WIDTH
cout  output  1  carry-out (add) / not-borrow (sub)

Behaviour:
- Arithmetic:
  - sub=0: {cout,sum} = a + b + cin.
  - sub=1: {cout,sum} = a + ~b + ~cin, i.e. a - b - cin. cout=1 means no borrow.
  - Inversion of b and cin happens at stage-0 capture.
- Pipeline structure:
  - Stage k (0..STAGES-1) adds chunk k of a/b with the carry registered from stage k-1. Stage 0 uses the effective carry-in.
  - Not-yet-added upper chunks are delayed alongside each stage.
  - Already-computed lower sum chunks are delayed alongside each stage, so all bits of a result emerge aligned.
  - Each stage has a valid bit. The last stage's registers drive out_valid, sum and cout directly.
- Advance and handshake:
  - adv = !out_valid | out_ready. All stages advance together when adv=1; no stage changes when adv=0.
  - in_ready = adv (combinational).
  - An operation is accepted when in_valid & in_ready. On adv, stage 0 valid <= in_valid.
  - A result is consumed when out_valid & out_ready.
  - Bubbles are not collapsed; an empty stage still takes one advance.
- Latency: STAGES cycles from acceptance to out_valid with no stalls. Throughput: 1 op/cycle.
- Stall: while out_valid=1 and out_ready=0:
  - sum, cout and out_valid hold stable.
  - in_ready=0; inputs are ignored.
- Simultaneous consume and accept in the same cycle is legal and sustains full throughput.
- Reset (async, any time, including mid-operation):
  - All stage valids, data registers, sum, cout and out_valid go to 0; in-flight operations are discarded.
  - in_ready=1 during and after reset, since out_valid=0.
  - Deassertion is used synchronously in the design's reset synchroniser (external); no internal synchroniser.
- STAGES=1: single registered ripple adder, latency 1.
- Invalid parameters (WIDTH % STAGES != 0) are flagged with an elaboration-time error.

Optional Feature:
- Macro: PIPELINED_CARRY_ADDER_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit): signed two's-complement overflow of the performed operation.
  - ovf = carry into MSB XOR carry out of MSB, computed in the last stage.
  - Registered and aligned with sum; reset 0; holds under stall.
- When undefined: no ovf port and no related logic.

Test Plan:
- WIDTH=16, STAGES=4, out_ready=1: a=0xFFFF, b=0x0001, cin=0, sub=0 -> exactly 4 cycles later out_valid=1, sum=0x0000, cout=1.
- sub=1: a=0x1234, b=0x0234, cin=0 -> sum=0x1000, cout=1. a=0x0000, b=0x0001, cin=0 -> sum=0xFFFF, cout=0. a=0x0005, b=0x0002, cin=1 -> sum=0x0002, cout=1.
- Stream of 8 back-to-back ops (a=i, b=0x0100*i, i=0..7) -> 8 consecutive results in order, one per cycle, starting cycle 4.
- Backpressure: out_ready=0 for 5 cycles while out_valid=1 -> sum/cout stable, in_ready=0, no ops lost or duplicated after release.
- Assert rst_n=0 with 3 ops in flight -> out_valid=0, sum=0, cout=0 immediately. After release, no stale results appear.
- With PIPELINED_CARRY_ADDER_OVF_EN: a=0x7FFF, b=0x0001, add -> ovf=1. a=0x8000, b=0x0001, sub -> ovf=1. a=0x0001, b=0x0001, add -> ovf=0.
